// File: rtl/gigatron_spi_pkg.sv
// Shared types and constants for the Gigatron expansion SPI byte engine.
package gigatron_spi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2
  } spi_state_t;

  // Extended ctrl device code that the decoder maps to this engine.
  localparam logic [3:0] SPI_DEV   = 4'hE;
  localparam logic [7:0] RXD_RESET = 8'hFF;

endpackage

// File: rtl/spi_half_timer.sv
// Loadable down-counter for one SCK half-period; tc is high while the count is zero.
module spi_half_timer #(
  parameter int W = 4
) (
  input  logic         CLK,
  input  logic         nRESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc
);

  logic [W-1:0] count;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/spi_byte_engine.sv
// Mode 0, MSB-first SPI byte shifter driven by START pulses from the ctrl decoder.
//
//  state | meaning
//  IDLE  | waiting for START, SCK low, MOSI holds last bit
//  LOW   | SCK low half-period; MOSI already presents the current bit
//  HIGH  | SCK high half-period; MISO was captured on entry
module spi_byte_engine
  import gigatron_spi_pkg::*;
#(
  parameter int DIV_W = 4,
  parameter int NBITS = 8
) (
  input  logic             CLK,
  input  logic             nRESET,
  input  logic             START,
  input  logic [NBITS-1:0] TXD,
  input  logic [DIV_W-1:0] DIV,
  input  logic             MISO,
  output logic             SCK,
  output logic             MOSI,
  output logic [NBITS-1:0] RXD,
  output logic             BUSY,
  output logic             DONE,
  output logic             OVR,
  input  logic             CLR_OVR
);

  localparam int CNT_W = (NBITS > 2) ? $clog2(NBITS) : 1;

  spi_state_t       state;
  logic [NBITS-2:0] tx_sr;     // bits still to be presented after the current one
  logic [NBITS-1:0] rx_sr;
  logic [CNT_W-1:0] bit_cnt;
  logic [DIV_W-1:0] div_q;

  logic             tmr_load;
  logic [DIV_W-1:0] tmr_val;
  logic             tmr_tc;

  // In IDLE the timer is primed from the live DIV so the first half-period is
  // already counting on the accept edge; afterwards every phase entry reloads div_q.
  assign tmr_load = (state == IDLE) ? START : tmr_tc;
  assign tmr_val  = (state == IDLE) ? DIV   : div_q;

  spi_half_timer #(.W(DIV_W)) u_half_timer (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  // Transfer sequencer: SCK phases, shift registers, status flags.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state   <= IDLE;
      SCK     <= 1'b0;
      MOSI    <= 1'b1;
      RXD     <= NBITS'(RXD_RESET);
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      OVR     <= 1'b0;
      tx_sr   <= '0;
      rx_sr   <= '0;
      bit_cnt <= '0;
      div_q   <= '0;
    end else begin
      DONE <= 1'b0;

      // CLR_OVR wins over an overrun in the same cycle.
      if (CLR_OVR) begin
        OVR <= 1'b0;
      end else if (START && BUSY) begin
        OVR <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (START) begin
            MOSI    <= TXD[NBITS-1];
            tx_sr   <= TXD[NBITS-2:0];
            bit_cnt <= CNT_W'(NBITS - 1);
            div_q   <= DIV;
            BUSY    <= 1'b1;
            state   <= LOW;
          end
        end

        LOW: begin
          if (tmr_tc) begin
            SCK   <= 1'b1;
            rx_sr <= {rx_sr[NBITS-2:0], MISO};
            state <= HIGH;
          end
        end

        HIGH: begin
          if (tmr_tc) begin
            SCK <= 1'b0;
            if (bit_cnt == '0) begin
              RXD   <= rx_sr;
              DONE  <= 1'b1;
              BUSY  <= 1'b0;
              state <= IDLE;
            end else begin
              MOSI    <= tx_sr[NBITS-2];
              tx_sr   <= tx_sr << 1;
              bit_cnt <= bit_cnt - 1'b1;
              state   <= LOW;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_byte_engine.sv
// Directed bench for spi_byte_engine; transfers push expectations, a DONE monitor checks them.
module tb_spi_byte_engine;

  logic       CLK;
  logic       nRESET;
  logic       START;
  logic [7:0] TXD;
  logic [3:0] DIV;
  logic       MISO;
  logic       SCK;
  logic       MOSI;
  logic [7:0] RXD;
  logic       BUSY;
  logic       DONE;
  logic       OVR;
  logic       CLR_OVR;

  logic loop_en;
  logic miso_drv;

  typedef struct {
    logic [7:0] rxd;
    int         cyc;
  } exp_t;

  exp_t sb_q[$];
  logic mosi_log[$];

  int cyc;
  int n_total;
  int n_pass;
  logic sck_prev;

  spi_byte_engine dut (
    .CLK     (CLK),
    .nRESET  (nRESET),
    .START   (START),
    .TXD     (TXD),
    .DIV     (DIV),
    .MISO    (MISO),
    .SCK     (SCK),
    .MOSI    (MOSI),
    .RXD     (RXD),
    .BUSY    (BUSY),
    .DONE    (DONE),
    .OVR     (OVR),
    .CLR_OVR (CLR_OVR)
  );

  assign MISO = loop_en ? MOSI : miso_drv;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Edge counter: after posedge n it reads n.
  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Scoreboard monitor: every DONE must match the oldest queued expectation.
  initial sck_prev = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (DONE === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected DONE: got pulse at edge %0d expected none", cyc);
      end else begin
        e = sb_q.pop_front();
        check("done rxd", {24'd0, RXD}, {24'd0, e.rxd});
        check("done edge", cyc, e.cyc);
      end
    end
    if (SCK === 1'b1 && sck_prev === 1'b0) mosi_log.push_back(MOSI);
    sck_prev = SCK;
  end

  // Issue START for one cycle; accept edge is the next posedge. Returns #1 after it.
  task automatic start_xfer(input logic [7:0] txd, input logic [3:0] div,
                            input logic [7:0] exp_rxd, input bit push);
    exp_t e;
    @(posedge CLK); #1;
    START = 1'b1;
    TXD   = txd;
    DIV   = div;
    if (push) begin
      e.rxd = exp_rxd;
      e.cyc = cyc + 1 + 2 * 8 * (int'(div) + 1);
      sb_q.push_back(e);
    end
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic drain(input int max_cyc);
    int n = 0;
    while (sb_q.size() != 0 && n < max_cyc) begin
      @(posedge CLK);
      n++;
    end
    check("drain", sb_q.size(), 0);
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    logic [7:0] b;
    int busy_cnt;
    int sck_hi;

    n_total  = 0;
    n_pass   = 0;
    nRESET   = 1'b0;
    START    = 1'b0;
    TXD      = 8'h00;
    DIV      = 4'd0;
    CLR_OVR  = 1'b0;
    loop_en  = 1'b1;
    miso_drv = 1'b0;

    repeat (2) @(posedge CLK); #1;
    check("reset sck",  SCK,  1'b0);
    check("reset mosi", MOSI, 1'b1);
    check("reset rxd",  RXD,  8'hFF);
    check("reset busy", BUSY, 1'b0);
    check("reset done", DONE, 1'b0);
    check("reset ovr",  OVR,  1'b0);
    nRESET = 1'b1;

    // DIV=0, A5 loopback
    mosi_log.delete();
    start_xfer(8'hA5, 4'd0, 8'hA5, 1'b1);
    drain(40);
    b = 8'h00;
    foreach (mosi_log[i]) b = {b[6:0], mosi_log[i]};
    check("a5 sck pulses", mosi_log.size(), 8);
    check("a5 mosi seq", b, 8'hA5);

    // DIV=3, 3C, MISO tied low
    loop_en  = 1'b0;
    miso_drv = 1'b0;
    mosi_log.delete();
    start_xfer(8'h3C, 4'd3, 8'h00, 1'b1);
    busy_cnt = 0;
    sck_hi   = 0;
    repeat (70) begin
      @(negedge CLK);
      if (BUSY === 1'b1) busy_cnt++;
      if (SCK === 1'b1) sck_hi++;
    end
    // BUSY visible after accept edge through edge 63: 64 sampled cycles.
    check("div3 busy cycles", busy_cnt, 64);
    check("div3 sck high cycles", sck_hi, 32);
    check("div3 sck pulses", mosi_log.size(), 8);
    drain(10);

    // Back-to-back: second START in the DONE cycle of the first
    loop_en = 1'b1;
    start_xfer(8'h5A, 4'd0, 8'h5A, 1'b1);
    repeat (15) @(posedge CLK);
    start_xfer(8'hFF, 4'd0, 8'hFF, 1'b1);
    check("b2b busy", BUSY, 1'b1);
    repeat (8) @(posedge CLK); #1;
    check("b2b rxd held", RXD, 8'h5A);
    drain(40);
    check("b2b ovr", OVR, 1'b0);

    // Overrun at edge 5 of a DIV=0 byte
    start_xfer(8'h96, 4'd0, 8'h96, 1'b1);
    repeat (4) @(posedge CLK); #1;
    START = 1'b1;
    TXD   = 8'h00;
    DIV   = 4'd15;
    @(posedge CLK); #1;
    START = 1'b0;
    check("ovr set", OVR, 1'b1);
    drain(40);
    check("ovr sticky", OVR, 1'b1);

    // CLR_OVR together with a fresh overrun
    start_xfer(8'h69, 4'd0, 8'h69, 1'b1);
    repeat (4) @(posedge CLK); #1;
    START   = 1'b1;
    CLR_OVR = 1'b1;
    TXD     = 8'h00;
    @(posedge CLK); #1;
    START   = 1'b0;
    CLR_OVR = 1'b0;
    check("ovr clr priority", OVR, 1'b0);
    drain(40);

    // Reset mid-byte while SCK is high
    loop_en  = 1'b0;
    miso_drv = 1'b0;
    start_xfer(8'h00, 4'd0, 8'h00, 1'b0);
    repeat (9) @(posedge CLK); #1;
    check("rst pre sck", SCK, 1'b1);
    nRESET = 1'b0;
    #1;
    check("rst async sck",  SCK,  1'b0);
    check("rst async mosi", MOSI, 1'b1);
    check("rst async busy", BUSY, 1'b0);
    check("rst async rxd",  RXD,  8'hFF);
    repeat (3) @(posedge CLK); #1;
    nRESET = 1'b1;
    repeat (30) @(posedge CLK); #1;
    check("rst after busy", BUSY, 1'b0);
    check("rst after rxd",  RXD,  8'hFF);

    // DIV change mid-byte has no effect
    loop_en = 1'b1;
    start_xfer(8'hC3, 4'd1, 8'hC3, 1'b1);
    repeat (2) @(posedge CLK); #1;
    DIV = 4'd15;
    drain(80);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
